// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs and per-stage write/flush/redirect controls between the pipeline and its
// central stall controller.
interface pipe_stall_ctrl_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic                IF_ICacheBusy;
  logic                ID_LoadUse;
  logic                EXE_DivBusy;
  logic                MEM_DCacheBusy;
  logic                MEM_ExceptValid;
  logic [PC_WIDTH-1:0] MEM_ExceptTarget;
  logic                MEM_IsTLBW;
  logic                MEM_IsTLBR;
  logic [PC_WIDTH-1:0] MEM_PC;

  logic                PC_Wr;
  logic                ID_Wr;
  logic                EXE_Wr;
  logic                MEM_Wr;
  logic                WB_Wr;
  logic                ID_Flush;
  logic                EXE_Flush;
  logic                MEM_Flush;
  logic                WB_Flush;
  logic                PC_RedirectValid;
  logic [PC_WIDTH-1:0] PC_RedirectTarget;
  logic                TLB_WrEn;
  logic                TLB_RdEn;

  // Pipeline side: reports hazards, consumes controls.
  modport master (
    output IF_ICacheBusy, ID_LoadUse, EXE_DivBusy, MEM_DCacheBusy, MEM_ExceptValid,
           MEM_ExceptTarget, MEM_IsTLBW, MEM_IsTLBR, MEM_PC,
    input  PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr, ID_Flush, EXE_Flush, MEM_Flush, WB_Flush,
           PC_RedirectValid, PC_RedirectTarget, TLB_WrEn, TLB_RdEn
  );

  // Controller side.
  modport slave (
    input  IF_ICacheBusy, ID_LoadUse, EXE_DivBusy, MEM_DCacheBusy, MEM_ExceptValid,
           MEM_ExceptTarget, MEM_IsTLBW, MEM_IsTLBR, MEM_PC,
    output PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr, ID_Flush, EXE_Flush, MEM_Flush, WB_Flush,
           PC_RedirectValid, PC_RedirectTarget, TLB_WrEn, TLB_RdEn
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: stall chain, exception and
// TLB-op redirects, and redirects held until the ICache can accept them.
module pipe_stall_ctrl #(
  parameter int unsigned TLB_OP_CYCLES = 2,
  parameter int unsigned PC_WIDTH      = 32
) (
  input logic              clk,
  input logic              rst,
  pipe_stall_ctrl_if.slave bus
);

  localparam int unsigned CntW = (TLB_OP_CYCLES > 1) ? $clog2(TLB_OP_CYCLES) : 1;

  typedef enum logic [1:0] {StRun, StTlbWait, StRedirPend} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] pend_q, pend_d;

  logic                tlb_hold;
  logic                s_mem, s_exe, s_id, s_if;
  logic                redir_req;
  logic [PC_WIDTH-1:0] redir_tgt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    redir_req = 1'b0;
    redir_tgt = '0;

    // A TLB op only starts once the MEM stage is free of a cache access and an exception.
    unique case (state_q)
      StRun:     tlb_hold = ~bus.MEM_DCacheBusy & ~bus.MEM_ExceptValid &
                            (bus.MEM_IsTLBW | bus.MEM_IsTLBR);
      StTlbWait: tlb_hold = (cnt_q != '0);
      default:   tlb_hold = 1'b0;
    endcase

    s_mem = bus.MEM_DCacheBusy | tlb_hold;
    s_exe = s_mem | bus.EXE_DivBusy;
    s_id  = s_exe | bus.ID_LoadUse;
    s_if  = s_id | bus.IF_ICacheBusy;

    bus.PC_Wr             = ~s_if;
    bus.ID_Wr             = ~s_id;
    bus.EXE_Wr            = ~s_exe;
    bus.MEM_Wr            = ~s_mem;
    bus.WB_Wr             = 1'b1;
    bus.ID_Flush          = s_if & ~s_id;
    bus.EXE_Flush         = s_id & ~s_exe;
    bus.MEM_Flush         = s_exe & ~s_mem;
    bus.WB_Flush          = s_mem;
    bus.PC_RedirectValid  = 1'b0;
    bus.PC_RedirectTarget = '0;
    bus.TLB_WrEn          = 1'b0;
    bus.TLB_RdEn          = 1'b0;

    unique case (state_q)
      StRun: begin
        if (bus.MEM_DCacheBusy) begin
          // Stall only; exception / TLB handling waits for the access to finish.
        end else if (bus.MEM_ExceptValid) begin
          bus.ID_Flush  = 1'b1;
          bus.EXE_Flush = 1'b1;
          bus.MEM_Flush = 1'b1;
          bus.WB_Flush  = 1'b1;
          bus.ID_Wr     = 1'b1;
          bus.EXE_Wr    = 1'b1;
          bus.MEM_Wr    = 1'b1;
          redir_req     = 1'b1;
          redir_tgt     = bus.MEM_ExceptTarget;
        end else if (bus.MEM_IsTLBW | bus.MEM_IsTLBR) begin
          bus.TLB_WrEn = bus.MEM_IsTLBW;
          bus.TLB_RdEn = bus.MEM_IsTLBR;
          cnt_d        = CntW'(TLB_OP_CYCLES - 1);
          state_d      = StTlbWait;
        end
      end
      StTlbWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          // Retire the TLB op and drop younger work translated with the old mapping.
          bus.MEM_Wr    = 1'b1;
          bus.MEM_Flush = 1'b1;
          bus.WB_Wr     = 1'b1;
          bus.WB_Flush  = 1'b0;
          bus.ID_Wr     = 1'b1;
          bus.EXE_Wr    = 1'b1;
          bus.ID_Flush  = 1'b1;
          bus.EXE_Flush = 1'b1;
          redir_req     = 1'b1;
          redir_tgt     = bus.MEM_PC + PC_WIDTH'(4);
          state_d       = StRun;
        end
      end
      StRedirPend: begin
        bus.ID_Flush = 1'b1;
        bus.PC_Wr    = 1'b0;
        if (!bus.IF_ICacheBusy) begin
          bus.PC_RedirectValid  = 1'b1;
          bus.PC_RedirectTarget = pend_q;
          bus.PC_Wr             = 1'b1;
          state_d               = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    // The ICache can only take a new PC when no fetch is in flight.
    if (redir_req) begin
      if (!bus.IF_ICacheBusy) begin
        bus.PC_RedirectValid  = 1'b1;
        bus.PC_RedirectTarget = redir_tgt;
        bus.PC_Wr             = 1'b1;
        state_d               = StRun;
      end else begin
        pend_d  = redir_tgt;
        state_d = StRedirPend;
      end
    end

    if (rst) begin
      bus.PC_Wr             = 1'b0;
      bus.ID_Wr             = 1'b0;
      bus.EXE_Wr            = 1'b0;
      bus.MEM_Wr            = 1'b0;
      bus.WB_Wr             = 1'b0;
      bus.ID_Flush          = 1'b1;
      bus.EXE_Flush         = 1'b1;
      bus.MEM_Flush         = 1'b1;
      bus.WB_Flush          = 1'b1;
      bus.PC_RedirectValid  = 1'b0;
      bus.PC_RedirectTarget = '0;
      bus.TLB_WrEn          = 1'b0;
      bus.TLB_RdEn          = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed-vector bench for pipe_stall_ctrl with hand-computed per-cycle expectations.
module tb_pipe_stall_ctrl;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  pipe_stall_ctrl_if #(.PC_WIDTH(32)) bus ();

  pipe_stall_ctrl #(
    .TLB_OP_CYCLES(2),
    .PC_WIDTH     (32)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // v = {ICacheBusy, LoadUse, DivBusy, DCacheBusy, ExceptValid, IsTLBW, IsTLBR}
  task automatic drive(input logic [6:0] v);
    bus.IF_ICacheBusy   = v[6];
    bus.ID_LoadUse      = v[5];
    bus.EXE_DivBusy     = v[4];
    bus.MEM_DCacheBusy  = v[3];
    bus.MEM_ExceptValid = v[2];
    bus.MEM_IsTLBW      = v[1];
    bus.MEM_IsTLBR      = v[0];
  endtask

  // wr = {PC,ID,EXE,MEM,WB}_Wr, fl = {ID,EXE,MEM,WB}_Flush, misc = {RedirValid,TLBWr,TLBRd}
  task automatic step(input string tag, input logic [6:0] v, input logic [4:0] wr,
                      input logic [3:0] fl, input logic [2:0] misc, input logic [31:0] tgt);
    drive(v);
    #1;
    check({tag, ".wr"}, 32'({bus.PC_Wr, bus.ID_Wr, bus.EXE_Wr, bus.MEM_Wr, bus.WB_Wr}),
          32'(wr));
    check({tag, ".flush"}, 32'({bus.ID_Flush, bus.EXE_Flush, bus.MEM_Flush, bus.WB_Flush}),
          32'(fl));
    check({tag, ".misc"}, 32'({bus.PC_RedirectValid, bus.TLB_WrEn, bus.TLB_RdEn}),
          32'(misc));
    check({tag, ".tgt"}, bus.PC_RedirectTarget, tgt);
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    drive(7'b0);
    bus.MEM_ExceptTarget = 32'hBFC0_0380;
    bus.MEM_PC           = 32'h8000_1000;
    @(negedge clk);

    // Reset forces all bubbles regardless of hazard inputs.
    step("rst0", 7'b0000000, 5'b00000, 4'b1111, 3'b000, 32'h0);
    step("rst1", 7'b0000110, 5'b00000, 4'b1111, 3'b000, 32'h0);
    rst = 1'b0;

    step("idle", 7'b0000000, 5'b11111, 4'b0000, 3'b000, 32'h0);

    for (int i = 0; i < 3; i++)
      step("dcache", 7'b0001000, 5'b00001, 4'b0001, 3'b000, 32'h0);
    step("dcache_clr", 7'b0000000, 5'b11111, 4'b0000, 3'b000, 32'h0);

    step("loaduse", 7'b0100000, 5'b00111, 4'b0100, 3'b000, 32'h0);
    step("icache",  7'b1000000, 5'b01111, 4'b1000, 3'b000, 32'h0);
    step("div",     7'b0010000, 5'b00011, 4'b0010, 3'b000, 32'h0);

    // Exception beats divider/load-use and redirects at once.
    step("exc_now", 7'b0110100, 5'b11111, 4'b1111, 3'b100, 32'hBFC0_0380);
    step("exc_after", 7'b0000000, 5'b11111, 4'b0000, 3'b000, 32'h0);

    // Exception while ICache busy: held in REDIR_PEND.
    step("exc_hold", 7'b1000100, 5'b01111, 4'b1111, 3'b000, 32'h0);
    for (int i = 0; i < 4; i++)
      step("pend", 7'b1000000, 5'b01111, 4'b1000, 3'b000, 32'h0);
    step("pend_go", 7'b0000000, 5'b11111, 4'b1000, 3'b100, 32'hBFC0_0380);
    step("pend_after", 7'b0000000, 5'b11111, 4'b0000, 3'b000, 32'h0);

    // TLBW, two stall cycles then retire + refetch at MEM_PC+4.
    step("tlbw_c0", 7'b0000010, 5'b00001, 4'b0001, 3'b010, 32'h0);
    step("tlbw_c1", 7'b0000010, 5'b00001, 4'b0001, 3'b000, 32'h0);
    step("tlbw_rel", 7'b0000010, 5'b11111, 4'b1110, 3'b100, 32'h8000_1004);
    step("tlbw_after", 7'b0000000, 5'b11111, 4'b0000, 3'b000, 32'h0);

    // TLBR at the top of the address space, release while ICache busy.
    bus.MEM_PC = 32'hFFFF_FFFC;
    step("tlbr_c0", 7'b1000001, 5'b00001, 4'b0001, 3'b001, 32'h0);
    step("tlbr_c1", 7'b1000001, 5'b00001, 4'b0001, 3'b000, 32'h0);
    step("tlbr_rel", 7'b1000001, 5'b01111, 4'b1110, 3'b000, 32'h0);
    step("tlbr_pend", 7'b1000000, 5'b01111, 4'b1000, 3'b000, 32'h0);
    bus.MEM_PC = 32'h1234_5678;
    step("tlbr_wrap", 7'b0000000, 5'b11111, 4'b1000, 3'b100, 32'h0000_0000);
    step("tlbr_after", 7'b0000000, 5'b11111, 4'b0000, 3'b000, 32'h0);

    // Reset in TLB_WAIT abandons the op: no strobe, no redirect afterwards.
    bus.MEM_PC = 32'h8000_1000;
    step("rtlb_c0", 7'b0000010, 5'b00001, 4'b0001, 3'b010, 32'h0);
    rst = 1'b1;
    step("rtlb_rst", 7'b0000010, 5'b00000, 4'b1111, 3'b000, 32'h0);
    rst = 1'b0;
    step("rtlb_n1", 7'b0000000, 5'b11111, 4'b0000, 3'b000, 32'h0);
    step("rtlb_n2", 7'b0000000, 5'b11111, 4'b0000, 3'b000, 32'h0);

    // Reset in REDIR_PEND loses the pending redirect.
    step("rpend_exc", 7'b1000100, 5'b01111, 4'b1111, 3'b000, 32'h0);
    rst = 1'b1;
    step("rpend_rst", 7'b1000000, 5'b00000, 4'b1111, 3'b000, 32'h0);
    rst = 1'b0;
    step("rpend_n1", 7'b0000000, 5'b11111, 4'b0000, 3'b000, 32'h0);

    // DCache busy defers a pending exception until it clears.
    bus.MEM_ExceptTarget = 32'h8000_0180;
    step("dc_exc0", 7'b0001100, 5'b00001, 4'b0001, 3'b000, 32'h0);
    step("dc_exc1", 7'b0000100, 5'b11111, 4'b1111, 3'b100, 32'h8000_0180);

    // DCache busy also defers a TLB op start.
    step("dc_tlb0", 7'b0001010, 5'b00001, 4'b0001, 3'b000, 32'h0);
    step("dc_tlb1", 7'b0000010, 5'b00001, 4'b0001, 3'b010, 32'h0);
    step("dc_tlb2", 7'b0000010, 5'b00001, 4'b0001, 3'b000, 32'h0);
    step("dc_tlb3", 7'b0000010, 5'b11111, 4'b1110, 3'b100, 32'h8000_1004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core (IF/ID/EXE/MEM/WB).
- Generates write-enable (X_Wr) and flush (X_Flush) for every pipeline register, including the EXE->MEM register's MEM_Wr/MEM_Flush.
- Sequences multi-cycle TLBW/TLBR ops held in MEM, then forces a refetch.
- Holds exception/refetch redirects until the ICache can accept them.

Parameters:
TLB_OP_CYCLES, 2, MEM stall cycles per TLBW/TLBR (>=1)
PC_WIDTH, 32, redirect/PC width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
IF_ICacheBusy  in  1  ICache fetch in flight; PC cannot update
ID_LoadUse  in  1  load-use hazard detected in ID
EXE_DivBusy  in  1  multi-cycle divider busy
MEM_DCacheBusy  in  1  DCache access in flight for MEM instruction
MEM_ExceptValid  in  1  exception/ERET committed by MEM instruction
MEM_ExceptTarget  in  32  exception vector / EPC
MEM_IsTLBW  in  1  MEM instruction is TLBWI/TLBWR
MEM_IsTLBR  in  1  MEM instruction is TLBR
MEM_PC  in  32  PC of MEM instruction
PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr  out  1 each  register write enables
ID_Flush, EXE_Flush, MEM_Flush, WB_Flush  out  1 each  load bubble (priority over Wr)
PC_RedirectValid  out  1  PC loads PC_RedirectTarget this cycle
PC_RedirectTarget  out  32  redirect address
TLB_WrEn  out  1  one-cycle TLB write strobe
TLB_RdEn  out  1  one-cycle TLB read strobe

Behaviour:
- State: RUN, TLB_WAIT, REDIR_PEND; registers: state, cnt, pend_target[31:0].
- Reset (rst=1 at posedge): state=RUN, cnt=0, pend_target=0. While rst=1, outputs are: all Wr=0, all Flush=1, PC_RedirectValid=0, TLB_WrEn=TLB_RdEn=0, PC_RedirectTarget=0.
- Outputs are combinational from state + inputs, so there is zero-cycle latency.
- Stall chain:
  - s_mem = MEM_DCacheBusy | tlb_hold
  - s_exe = s_mem | EXE_DivBusy
  - s_id = s_exe | ID_LoadUse
  - s_if = s_id | IF_ICacheBusy
- Base outputs:
  - PC_Wr = ~s_if; ID_Wr = ~s_id; EXE_Wr = ~s_exe; MEM_Wr = ~s_mem; WB_Wr = 1.
  - ID_Flush = s_if & ~s_id; EXE_Flush = s_id & ~s_exe; MEM_Flush = s_exe & ~s_mem; WB_Flush = s_mem.
- RUN, checks in priority order:
  1. MEM_DCacheBusy=1: stall only. Exception and TLB handling are deferred until it clears.
  2. MEM_ExceptValid: force ID/EXE/MEM/WB_Flush=1 and ID/EXE/MEM_Wr=1.
     - If ~IF_ICacheBusy: PC_RedirectValid=1, PC_RedirectTarget=MEM_ExceptTarget, PC_Wr=1; stay RUN.
     - Else: pend_target<=MEM_ExceptTarget, go to REDIR_PEND.
     - Exception beats ID_LoadUse and EXE_DivBusy.
  3. MEM_IsTLBW|MEM_IsTLBR: tlb_hold=1, TLB_WrEn=MEM_IsTLBW, TLB_RdEn=MEM_IsTLBR, cnt<=TLB_OP_CYCLES-1, go to TLB_WAIT.
- TLB_WAIT:
  - cnt!=0: tlb_hold=1, cnt<=cnt-1. Strobes stay 0.
  - cnt==0 (release):
    - MEM_Wr=1 with MEM_Flush=1; WB_Wr=1, WB_Flush=0, so the TLB instruction retires.
    - ID_Flush=EXE_Flush=1 and ID_Wr=EXE_Wr=1, discarding younger instructions translated with the stale TLB.
    - Redirect target = MEM_PC+4, same rule as an exception: issue now if ~IF_ICacheBusy and go to RUN, else latch and go to REDIR_PEND.
  - Total MEM stall = TLB_OP_CYCLES cycles; the release is the following cycle.
- REDIR_PEND:
  - ID_Flush=1 every cycle, discarding the wrong-path fetch in flight; PC_Wr=0.
  - When IF_ICacheBusy=0: PC_RedirectValid=1, target=pend_target, PC_Wr=1, go to RUN.
  - Downstream stages follow the stall chain normally.
- Wrap: MEM_PC+4 is modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- TLB ops in a branch delay slot are illegal; behaviour for them is undefined.
- Reset mid-TLB_WAIT or mid-REDIR_PEND: the op is abandoned, there is no strobe, and the pending redirect is lost.

Test Plan:
- MEM_DCacheBusy=1 for 3 cycles -> PC/ID/EXE/MEM_Wr=0 and WB_Flush=1 for 3 cycles; the cycle after busy clears, all Wr=1 and all Flush=0.
- ID_LoadUse=1 for 1 cycle -> PC_Wr=ID_Wr=0, EXE_Flush=1, MEM_Wr=1.
- MEM_ExceptValid=1 with MEM_ExceptTarget=0xBFC00380 and IF_ICacheBusy=0 -> same cycle: PC_RedirectValid=1, target=0xBFC00380, ID/EXE/MEM/WB_Flush=1.
- Same exception with IF_ICacheBusy=1 for 4 cycles -> REDIR_PEND with ID_Flush=1 for 4 cycles; 5th cycle: PC_RedirectValid=1, target=0xBFC00380, state RUN.
- TLBW with MEM_PC=0x80001000, TLB_OP_CYCLES=2 -> TLB_WrEn pulses exactly once on cycle 0; MEM_Wr=0 on cycles 0-1; cycle 2: redirect 0x80001004 with ID/EXE/MEM_Flush=1 and WB_Wr=1.
- rst asserted in TLB_WAIT (cnt=1) -> next cycle state RUN, no further TLB strobes, and no redirect.
